aes_128_core: RTL and testbench
===============================

// Module: aes_128_core
// PURPOSE
//  Fully pipelined AES-128 encryption engine (FIPS-197, encrypt only).
//  Accepts one 128-bit plaintext block and one 128-bit key per clock.
//  Emits the ciphertext a fixed 20 cycles later, with throughput of one block per cycle.
//  Sits in the datapath as the cipher primitive; key expansion runs on the fly inside the pipeline.
// PARAMETERS
//  none (fixed AES-128: Nk=4, Nr=10, 128-bit block)
// PORTS
//  clk        in   1    rising-edge clock; the only clock
//  reset_n    in   1    asynchronous, active-low reset
//  IN_valid   in   1    IN_state/key valid; sampled every rising edge
//  IN_state   in   128  plaintext; [127:120] = byte in[0] ... [7:0] = in[15] (FIPS column-major)
//  key        in   128  cipher key, same byte order; may change every cycle
//  OUT_valid  out  1    OUT_state holds a ciphertext this cycle
//  OUT_state  out  128  ciphertext, same byte order
// BEHAVIOUR
//  - Reset: while reset_n=0 (async assert), every pipeline valid bit clears; OUT_valid=0, OUT_state=0.
//    Data/key pipeline registers also clear to 0. Release is synchronous to the next edge.
//  - Pipeline has 20 register stages, each carrying {valid, state, round_key}:
//    S0: state = IN_state ^ key; rk = key; valid = IN_valid.
//    Rounds r=1..9 take two stages each:
//      A: SubBytes + ShiftRows on state; rk_next = KeyExpand(rk, Rcon[r]).
//      B: MixColumns, then ^ rk_next.
//    Round 10 is one stage: SubBytes + ShiftRows, then ^ KeyExpand(rk, Rcon[10]); this stage drives OUT_*.
//  - Latency: block sampled at edge k (IN_valid=1) appears on OUT_state with OUT_valid=1 after edge k+19.
//    It holds for exactly one cycle, so results are visible from just after edge k+19 until edge k+20.
//  - IN_valid held high with constant inputs: OUT_valid stays 1 continuously from edge k+19.
//    OUT_state stays constant over that interval.
//  - Valid gaps propagate unchanged.
//    OUT_valid=0 cycles line up with IN_valid=0 cycles delayed by 20.
//  - When OUT_valid=0, OUT_state is don't-care, but it must be deterministic (no X after reset).
//  - KeyExpand(w0..w3, rc): t = SubWord(RotWord(w3)) ^ {rc,24'h0}.
//    w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
//    Rcon = 01,02,04,08,10,20,40,80,1b,36.
//  - S-box: standard AES table as a combinational case ROM, one instance per byte per stage (16 per A stage + 4 for key).
//  - MixColumns: GF(2^8) xtime with polynomial 0x11b; per column matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2].
//  - ShiftRows: row i (bytes i, i+4, i+8, i+12) rotates left by i.
//  - No backpressure and no stall; every accepted block completes.
//  - Reset mid-flight: all in-flight blocks are discarded (valids cleared).
//    OUT_valid stays 0 until 20 edges after the first post-reset IN_valid=1 edge.
//  - No combinational path from inputs to outputs.
// TESTING
//  1. FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
//     Hold IN_valid=1 -> OUT_state=3925841d02dc09fbdc118597196a0b32.
//     OUT_valid=1 after edge k+19 and still 1 after k+20.
//  2. FIPS-197 App.C.1: key 000102...0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
//  3. Zero key, zero pt -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
//  4. Back-to-back: vectors 1,2,3 on consecutive edges, then IN_valid=0.
//     -> three consecutive OUT_valid cycles with the three ciphertexts in order, then OUT_valid=0.
//  5. Bubble: vector 1, idle cycle, vector 2 -> OUT_valid pattern 1,0,1 with the correct ciphertexts.
//  6. Reset: assert reset_n=0 for one cycle, 5 edges after feeding vector 1.
//     -> OUT_valid and OUT_state go 0 immediately; no output appears for the discarded block.

Source files
------------

// File: rtl/aes_128_core_if.sv
// aes_128_core_if: block-in / block-out bundle between a data source and the AES-128 core
interface aes_128_core_if;
  logic         IN_valid;
  logic [127:0] IN_state;
  logic [127:0] key;
  logic         OUT_valid;
  logic [127:0] OUT_state;
  modport master (output IN_valid, IN_state, key, input OUT_valid, OUT_state);
  modport slave (input IN_valid, IN_state, key, output OUT_valid, OUT_state);
endinterface

// File: rtl/aes_128_core.sv
// aes_128_core: fully pipelined AES-128 encryptor, one block per clock, 20-stage latency
module aes_128_core (
  input logic clk,
  input logic reset_n,
  aes_128_core_if.slave bus
);
  localparam logic [79:0] RCON = 80'h01020408102040801b36;
  // AES S-box as a ROM: high nibble selects a row, low nibble selects the byte in it
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [127:0] row;
    case (a[7:4])
      4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
      default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
    endcase
    return row[{~a[3:0], 3'b000} +: 8];
  endfunction
  // multiply by x in GF(2^8) modulo 0x11b
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  // SubBytes followed by ShiftRows; byte (row r, col c) comes from (row r, col c+r)
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-32*c-8*r -: 8] = sbox(s[127-32*((c+r)%4)-8*r -: 8]);
    return o;
  endfunction
  // MixColumns with matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2] per column
  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction
  // one AES-128 key schedule step: next four words from the current four
  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  logic [18:0]  v;
  logic [127:0] st [0:18];
  logic [127:0] rk [0:18];
  logic         ov;
  logic [127:0] os;
  // stage 0 whitens with the key, rounds 1-9 split into SubShift/key step then MixColumns/AddRoundKey, round 10 drives the outputs
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      v <= '0;
      for (int i = 0; i < 19; i++) begin
        st[i] <= '0;
        rk[i] <= '0;
      end
      ov <= 1'b0;
      os <= '0;
    end else begin
      v[0] <= bus.IN_valid;
      st[0] <= bus.IN_state ^ bus.key;
      rk[0] <= bus.key;
      for (int r = 1; r < 10; r++) begin
        v[2*r-1] <= v[2*r-2];
        st[2*r-1] <= sub_shift(st[2*r-2]);
        rk[2*r-1] <= key_expand(rk[2*r-2], RCON[87-8*r -: 8]);
        v[2*r] <= v[2*r-1];
        st[2*r] <= mix(st[2*r-1]) ^ rk[2*r-1];
        rk[2*r] <= rk[2*r-1];
      end
      ov <= v[18];
      os <= sub_shift(st[18]) ^ key_expand(rk[18], RCON[7:0]);
    end
  assign bus.OUT_valid = ov;
  assign bus.OUT_state = os;
endmodule

// File: tb/tb_aes_128_core.sv
// tb_aes_128_core: known-answer, pipelining, bubble, reset and randomized checks of the AES-128 core
module tb_aes_128_core;
  logic clk;
  logic reset_n;
  int errors = 0;
  int checks = 0;
  logic [7:0] sb_t [256];
  localparam logic [127:0] VK [3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                                      128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] VP [3] = '{128'h3243f6a8885a308d313198a2e0370734,
                                      128'h00112233445566778899aabbccddeeff, 128'h0};
  localparam logic [127:0] VC [3] = '{128'h3925841d02dc09fbdc118597196a0b32,
                                      128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                                      128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
  aes_128_core_if bus ();
  aes_128_core dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // S-box derived from its definition: multiplicative inverse then the affine map
  task automatic build_sbox();
    logic [7:0] b;
    for (int a = 0; a < 256; a++) begin
      b = 8'h01;
      for (int i = 0; i < 254; i++) b = gmul(b, 8'(a));
      if (a == 0) b = 8'h00;
      sb_t[a] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask
  // textbook AES-128: full key schedule first, then ten rounds over a byte array
  function automatic logic [127:0] ref_enc(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] s [16];
    logic [7:0] u [16];
    logic [7:0] rc;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb_t[t[23:16]], sb_t[t[15:8]], sb_t[t[7:0]], sb_t[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int n = 0; n < 16; n++) u[n] = sb_t[s[4*((n/4 + n%4) % 4) + n%4]];
      for (int c = 0; c < 4; c++)
        for (int i = 0; i < 4; i++)
          s[4*c+i] = (r == 10) ? u[4*c+i] : gmul(u[4*c+i], 8'h02) ^ gmul(u[4*c+(i+1)%4], 8'h03)
                                            ^ u[4*c+(i+2)%4] ^ u[4*c+(i+3)%4];
      for (int n = 0; n < 16; n++) s[n] ^= w[4*r + n/4][31-8*(n%4) -: 8];
    end
    o = '0;
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = s[n];
    return o;
  endfunction
  // drive one cycle of inputs, let the edge sample them, then read the outputs 1 time unit later
  task automatic cyc(input logic iv, input logic [127:0] p, input logic [127:0] k,
                     output logic ov, output logic [127:0] os);
    bus.IN_valid = iv;
    bus.IN_state = p;
    bus.key = k;
    @(posedge clk);
    #1;
    ov = bus.OUT_valid;
    os = bus.OUT_state;
  endtask
  task automatic test_reset();
    logic ov;
    logic [127:0] os;
    reset_n = 1'b1;
    bus.IN_valid = 1'b0;
    bus.IN_state = '0;
    bus.key = '0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.OUT_valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b expected 0", bus.OUT_valid); end
    checks++;
    if (bus.OUT_state !== '0) begin errors++; $display("FAIL reset state: got %h expected 0", bus.OUT_state); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      cyc(1'b0, '0, '0, ov, os);
      checks++;
      if (ov !== 1'b0) begin errors++; $display("FAIL idle after reset valid: got %b expected 0", ov); end
    end
  endtask
  task automatic test_hold(input int idx);
    logic ov;
    logic [127:0] os;
    for (int j = 0; j < 22; j++) begin
      cyc(1'b1, VP[idx], VK[idx], ov, os);
      if (j == 18) begin
        checks++;
        if (ov !== 1'b0) begin errors++; $display("FAIL hold%0d early valid: got %b expected 0", idx, ov); end
      end
      if (j >= 19) begin
        checks++;
        if (ov !== 1'b1) begin errors++; $display("FAIL hold%0d valid edge %0d: got %b expected 1", idx, j, ov); end
        checks++;
        if (os !== VC[idx]) begin errors++; $display("FAIL hold%0d data edge %0d: got %h expected %h", idx, j, os, VC[idx]); end
      end
    end
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, '0, '0, ov, os);
      if (i >= 18) begin
        checks++;
        if (ov !== (i == 18)) begin errors++; $display("FAIL hold%0d tail valid %0d: got %b expected %b", idx, i, ov, i == 18); end
      end
    end
  endtask
  // feeds a sequence of known vectors (-1 = idle) and checks the exact output cycle pattern
  task automatic run_seq(input string name, input int s0, input int s1, input int s2);
    int sel [3];
    int e;
    logic ov, ev;
    logic [127:0] os;
    sel = '{s0, s1, s2};
    for (int j = 0; j < 25; j++) begin
      if (j < 3 && sel[j] >= 0) cyc(1'b1, VP[sel[j]], VK[sel[j]], ov, os);
      else cyc(1'b0, '0, '0, ov, os);
      e = j - 19;
      ev = (e >= 0 && e < 3) ? (sel[e] >= 0) : 1'b0;
      checks++;
      if (ov !== ev) begin errors++; $display("FAIL %s valid edge %0d: got %b expected %b", name, j, ov, ev); end
      if (ev) begin
        checks++;
        if (os !== VC[sel[e]]) begin errors++; $display("FAIL %s data edge %0d: got %h expected %h", name, j, os, VC[sel[e]]); end
      end
    end
  endtask
  task automatic test_back_to_back();
    run_seq("back_to_back", 0, 1, 2);
  endtask
  task automatic test_bubble();
    run_seq("bubble", 0, -1, 1);
  endtask
  task automatic test_random();
    logic lv [48];
    logic [127:0] lp [48];
    logic [127:0] lk [48];
    logic ov, ev;
    logic [127:0] os, eo;
    int e;
    for (int j = 0; j < 48; j++) begin
      lv[j] = ($urandom_range(3) != 0);
      lp[j] = {$urandom, $urandom, $urandom, $urandom};
      lk[j] = (j > 0 && $urandom_range(1) == 1) ? lk[j-1] : {$urandom, $urandom, $urandom, $urandom};
    end
    for (int j = 0; j < 68; j++) begin
      if (j < 48) cyc(lv[j], lp[j], lk[j], ov, os);
      else cyc(1'b0, '0, '0, ov, os);
      e = j - 19;
      ev = (e >= 0 && e < 48) ? lv[e] : 1'b0;
      checks++;
      if (ov !== ev) begin errors++; $display("FAIL random valid edge %0d: got %b expected %b", j, ov, ev); end
      if (ev) begin
        eo = ref_enc(lk[e], lp[e]);
        checks++;
        if (os !== eo) begin errors++; $display("FAIL random data edge %0d: got %h expected %h", j, os, eo); end
      end
    end
  endtask
  task automatic test_reset_midflight();
    logic ov;
    logic [127:0] os;
    cyc(1'b1, VP[0], VK[0], ov, os);
    for (int j = 0; j < 5; j++) cyc(1'b0, '0, '0, ov, os);
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.OUT_valid !== 1'b0) begin errors++; $display("FAIL midreset valid: got %b expected 0", bus.OUT_valid); end
    checks++;
    if (bus.OUT_state !== '0) begin errors++; $display("FAIL midreset state: got %h expected 0", bus.OUT_state); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int j = 0; j < 25; j++) begin
      cyc(1'b0, '0, '0, ov, os);
      checks++;
      if (ov !== 1'b0) begin errors++; $display("FAIL midreset discarded block valid cycle %0d: got %b expected 0", j, ov); end
    end
    for (int j = 0; j < 21; j++) begin
      cyc(j == 0, j == 0 ? VP[1] : '0, j == 0 ? VK[1] : '0, ov, os);
      checks++;
      if (ov !== (j == 19)) begin errors++; $display("FAIL post-reset valid edge %0d: got %b expected %b", j, ov, j == 19); end
      if (j == 19) begin
        checks++;
        if (os !== VC[1]) begin errors++; $display("FAIL post-reset data: got %h expected %h", os, VC[1]); end
      end
    end
  endtask
  initial begin
    build_sbox();
    test_reset();
    for (int i = 0; i < 3; i++) test_hold(i);
    test_back_to_back();
    test_bubble();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
